// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the chunked adder.
// The configuration check is invoked by the top level.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } add_state_t;

    function automatic int num_chunks(input int w, input int c);
        return w / c;
    endfunction

    function automatic int idx_width(input int w, input int c);
        return (w / c > 1) ? $clog2(w / c) : 1;
    endfunction

    function automatic bit cfg_ok(input int w, input int c);
        return (c >= 1) && (c <= w) && (w % c == 0);
    endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational CHUNK-bit slice adder with carry in/out.
// One instance is reused every cycle by the chunked adder.
module chunk_add #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign s    = full[CHUNK-1:0];
    assign cout = full[CHUNK];

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock,
// with valid/ready handshakes on operands and result.
module chunked_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NC   = num_chunks(WIDTH, CHUNK);
    localparam int IDXW = idx_width(WIDTH, CHUNK);

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("chunked_adder: WIDTH must be a multiple of CHUNK");
    end

    add_state_t                  state;
    logic [IDXW-1:0]             idx;
    logic [NC-1:0][CHUNK-1:0]    a_q;
    logic [NC-1:0][CHUNK-1:0]    b_q;
    logic [NC-1:0][CHUNK-1:0]    sum_q;
    logic                        carry_q;
    logic [CHUNK-1:0]            s;
    logic                        c;
    logic                        last;

    chunk_add #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .a   (a_q[idx]),
        .b   (b_q[idx]),
        .cin (carry_q),
        .s   (s),
        .cout(c)
    );

    assign last = (idx == IDXW'(NC - 1));
    assign sum  = sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum_q     <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            idx       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= sub ? ~b : b;
                        carry_q  <= sub ? 1'b1 : carry_in;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    sum_q[idx] <= s;
                    carry_q    <= c;
                    if (last) begin
                        carry_out <= c;
                        // Signed overflow: like-signed operands, result sign flipped
                        overflow  <= (a_q[NC-1][CHUNK-1] == b_q[NC-1][CHUNK-1])
                                  && (s[CHUNK-1] != a_q[NC-1][CHUNK-1]);
                        idx       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_adder.sv
// Directed and sweep bench for chunked_adder at WIDTH=8/CHUNK=4
// and WIDTH=4 with CHUNK of 1, 2 and 4.
module tb_chunked_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // 8-bit instance
    logic       iv8 = 1'b0, or8 = 1'b0, ci8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ir8, ov8, co8, of8;
    logic [7:0] s8;

    // 4-bit instances share stimulus
    logic       iv4 = 1'b0, or4 = 1'b0, ci4 = 1'b0, sub4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [2:0] ir4, ovl4, co4, of4;
    logic [3:0] s4 [3];

    chunked_adder #(.WIDTH(8), .CHUNK(4)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .carry_in(ci8), .sub(sub8),
        .out_valid(ov8), .out_ready(or8), .sum(s8),
        .carry_out(co8), .overflow(of8)
    );

    chunked_adder #(.WIDTH(4), .CHUNK(1)) u41 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4[0]),
        .a(a4), .b(b4), .carry_in(ci4), .sub(sub4),
        .out_valid(ovl4[0]), .out_ready(or4), .sum(s4[0]),
        .carry_out(co4[0]), .overflow(of4[0])
    );

    chunked_adder #(.WIDTH(4), .CHUNK(2)) u42 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4[1]),
        .a(a4), .b(b4), .carry_in(ci4), .sub(sub4),
        .out_valid(ovl4[1]), .out_ready(or4), .sum(s4[1]),
        .carry_out(co4[1]), .overflow(of4[1])
    );

    chunked_adder #(.WIDTH(4), .CHUNK(4)) u44 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4[2]),
        .a(a4), .b(b4), .carry_in(ci4), .sub(sub4),
        .out_valid(ovl4[2]), .out_ready(or4), .sum(s4[2]),
        .carry_out(co4[2]), .overflow(of4[2])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 8-bit operation; hold>0 exercises output backpressure
    task automatic op8(input string tag, input logic [7:0] a,
                       input logic [7:0] b, input logic ci,
                       input logic sb, input logic [7:0] es,
                       input logic eco, input logic eof,
                       input int hold);
        int lat;
        a8 = a; b8 = b; ci8 = ci; sub8 = sb; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        a8 = ~a; b8 = ~b; sub8 = ~sb;
        lat = 0;
        while (!ov8 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, 2);
        check({tag, "_sum"}, s8, es);
        check({tag, "_co"}, co8, eco);
        check({tag, "_ov"}, of8, eof);
        for (int i = 0; i < hold; i++) begin
            iv8 = (i == 2);
            a8 = 8'hAA; b8 = 8'h55;
            tick();
            check({tag, "_bp_sum"}, s8, es);
            check({tag, "_bp_vld"}, ov8, 1'b1);
            check({tag, "_bp_rdy"}, ir8, 1'b0);
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        check({tag, "_idle_rdy"}, ir8, 1'b1);
        check({tag, "_idle_vld"}, ov8, 1'b0);
        if (hold > 0) begin
            tick();
            tick();
            tick();
            check({tag, "_no_start"}, ov8, 1'b0);
            check({tag, "_still_rdy"}, ir8, 1'b1);
        end
    endtask

    task automatic ref4(input logic [3:0] a, input logic [3:0] b,
                        input logic ci, input logic sb,
                        output logic [3:0] s, output logic co,
                        output logic ov);
        logic [3:0] be;
        logic [4:0] f;
        be = sb ? ~b : b;
        f  = {1'b0, a} + {1'b0, be} + {4'd0, (sb ? 1'b1 : ci)};
        s  = f[3:0];
        co = f[4];
        ov = (a[3] == be[3]) && (s[3] != a[3]);
    endtask

    initial begin
        logic [3:0] es;
        logic       eco, eov;
        int         lat [3];
        int         t;

        tick();
        check("rst_rdy", ir8, 1'b1);
        check("rst_vld", ov8, 1'b0);
        check("rst_sum", s8, 8'h00);
        check("rst_co", co8, 1'b0);
        check("rst_ov", of8, 1'b0);
        rst_n = 1'b1;
        tick();

        op8("ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        op8("7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        op8("5m7", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 0);
        op8("80m1", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
        op8("12_34c", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, 0);
        op8("0m0", 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 0);
        op8("bp", 8'h33, 8'h11, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0, 5);

        // Reset during the first BUSY cycle
        a8 = 8'h40; b8 = 8'h40; ci8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        check("mid_busy", ir8, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mr_vld", ov8, 1'b0);
        check("mr_sum", s8, 8'h00);
        check("mr_rdy", ir8, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        op8("10_20", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 0);

        // Exhaustive 4-bit sweep across three chunk sizes
        for (int sb = 0; sb < 2; sb++)
        for (int ci = 0; ci < 2; ci++)
        for (int av = 0; av < 16; av++)
        for (int bv = 0; bv < 16; bv++) begin
            a4 = 4'(av); b4 = 4'(bv);
            ci4 = 1'(ci); sub4 = 1'(sb);
            ref4(a4, b4, ci4, sub4, es, eco, eov);
            iv4 = 1'b1;
            tick();
            iv4 = 1'b0;
            a4 = ~a4; b4 = ~b4; ci4 = ~ci4;
            lat = '{-1, -1, -1};
            t = 0;
            while ((lat[0] < 0 || lat[1] < 0 || lat[2] < 0) && t < 12) begin
                tick();
                t++;
                for (int k = 0; k < 3; k++)
                    if (ovl4[k] && lat[k] < 0) lat[k] = t;
            end
            check("w4c1_lat", lat[0], 4);
            check("w4c2_lat", lat[1], 2);
            check("w4c4_lat", lat[2], 1);
            for (int k = 0; k < 3; k++) begin
                check("w4_sum", s4[k], es);
                check("w4_co", co4[k], eco);
                check("w4_ov", of4[k], eov);
            end
            or4 = 1'b1;
            tick();
            or4 = 1'b0;
            check("w4_idle", ir4, 3'b111);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
